player_motion_ctrl: RTL and testbench

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/player_motion_ctrl_if.sv | 14 +
 rtl/player_motion_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_ctrl_if.sv
// Collision lookup handshake between the motion controller (master)
// and the tile collision map (slave).
`timescale 1ns/1ps
interface player_motion_ctrl_if;
  logic        coll_req;
  logic [11:0] coll_addr;
  logic        coll_valid;
  logic        coll_data;

  modport master (output coll_req, output coll_addr,
                  input  coll_valid, input coll_data);
  modport slave  (input  coll_req, input coll_addr,
                  output coll_valid, output coll_data);
endinterface

// File: rtl/player_motion_ctrl.sv
// Tile-based player motion controller. A move request on a frame tick
// picks a neighbouring tile and the player slides there 1 px (walk) or
// 2 px (run) per frame tick, then snaps to the exact tile origin.
// Optional feature macro: COLLISION_EN -- when defined, each in-map step
// first queries the collision map (CHECK/WAIT); when undefined the lookup
// port is tied off and in-map steps start immediately.
`timescale 1ns/1ps
module player_motion_ctrl #(
  parameter int TILE_PX      = 16,
  parameter int MAP_W        = 64,
  parameter int MAP_H        = 64,
  parameter int START_TX     = 10,
  parameter int START_TY     = 12,
  parameter int COLL_TIMEOUT = 15
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   VGA_VS,
  input  logic [3:0]             state_num,
  input  logic                   charIsMoving,
  input  logic                   charIsRunning,
  input  logic [1:0]             direction,
  player_motion_ctrl_if.master   coll,
  output logic [9:0]             map_x,
  output logic [9:0]             map_y,
  output logic [1:0]             facing,
  output logic                   step_active,
  output logic                   bump
);

  localparam int          OFF_W   = $clog2(TILE_PX) + 1;
  localparam logic [10:0] MAP_W_L = 11'(MAP_W);
  localparam logic [10:0] MAP_H_L = 11'(MAP_H);

`ifdef COLLISION_EN
  localparam int TO_W = $clog2(COLL_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CHECK, WAIT, STEP} state_t;
  logic            coll_req_q;
  logic [11:0]     coll_addr_q;
  logic [TO_W-1:0] timer;
`else
  typedef enum logic {IDLE, STEP} state_t;
`endif

  state_t           state;
  logic             vs_s1, vs_s2, vs_q;
  logic             frame_tick;
  logic             in_game;
  logic [9:0]       tx, ty;
  logic [9:0]       dst_tx, dst_ty;
  logic [9:0]       tgt_tx, tgt_ty;
  logic [10:0]      tx_inc, ty_inc;
  logic             out_of_map;
  logic [1:0]       dir_q;
  logic             run_q;
  logic [OFF_W-1:0] offset;
  logic [OFF_W-1:0] new_off;
  logic [9:0]       step_px;

  function automatic logic [9:0] tile_px(input logic [9:0] t);
    return 10'(32'(t) * TILE_PX);
  endfunction

  assign frame_tick = vs_s2 & ~vs_q;
  assign in_game    = (state_num == 4'd3);
  assign tx_inc     = {1'b0, tx} + 11'd1;
  assign ty_inc     = {1'b0, ty} + 11'd1;
  assign step_px    = run_q ? 10'd2 : 10'd1;
  assign new_off    = offset + (run_q ? OFF_W'(2) : OFF_W'(1));

`ifdef COLLISION_EN
  assign coll.coll_req  = coll_req_q;
  assign coll.coll_addr = coll_addr_q;
`else
  logic coll_unused;
  assign coll.coll_req  = 1'b0;
  assign coll.coll_addr = '0;
  assign coll_unused    = coll.coll_valid ^ coll.coll_data;
`endif

  // Two-flop synchroniser for VGA_VS plus a delay flop for edge detection
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      vs_s1 <= VGA_VS;
      vs_s2 <= vs_s1;
      vs_q  <= vs_s2;
    end
  end

  // Neighbouring tile for the currently requested direction and map-edge test
  always_comb begin
    tgt_tx     = tx;
    tgt_ty     = ty;
    out_of_map = 1'b0;
    case (direction)
      2'd0: if (ty_inc >= MAP_H_L) out_of_map = 1'b1; else tgt_ty = ty_inc[9:0];
      2'd1: if (ty == '0)          out_of_map = 1'b1; else tgt_ty = ty - 10'd1;
      2'd2: if (tx == '0)          out_of_map = 1'b1; else tgt_tx = tx - 10'd1;
      default: if (tx_inc >= MAP_W_L) out_of_map = 1'b1; else tgt_tx = tx_inc[9:0];
    endcase
  end

  // Motion FSM: request capture, optional collision lookup, pixel stepping
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      tx          <= 10'(START_TX);
      ty          <= 10'(START_TY);
      dst_tx      <= 10'(START_TX);
      dst_ty      <= 10'(START_TY);
      map_x       <= 10'(START_TX * TILE_PX);
      map_y       <= 10'(START_TY * TILE_PX);
      facing      <= '0;
      dir_q       <= '0;
      run_q       <= 1'b0;
      step_active <= 1'b0;
      bump        <= 1'b0;
      offset      <= '0;
`ifdef COLLISION_EN
      coll_req_q  <= 1'b0;
      coll_addr_q <= '0;
      timer       <= '0;
`endif
    end else begin
      bump <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick && in_game && charIsMoving) begin
            facing <= direction;
            dir_q  <= direction;
            run_q  <= charIsRunning;
            dst_tx <= tgt_tx;
            dst_ty <= tgt_ty;
            if (out_of_map) begin
              bump <= 1'b1;
            end else begin
              step_active <= 1'b1;
`ifdef COLLISION_EN
              coll_req_q  <= 1'b1;
              coll_addr_q <= 12'(32'(tgt_ty) * MAP_W + 32'(tgt_tx));
              state       <= CHECK;
`else
              offset      <= '0;
              state       <= STEP;
`endif
            end
          end
        end
`ifdef COLLISION_EN
        CHECK: begin
          // timer counts clocks since coll_req rose, so a timeout lands
          // exactly COLL_TIMEOUT clocks after the request
          coll_req_q <= 1'b0;
          timer      <= TO_W'(1);
          state      <= WAIT;
        end
        WAIT: begin
          if (coll.coll_valid) begin
            if (coll.coll_data) begin
              bump        <= 1'b1;
              step_active <= 1'b0;
              state       <= IDLE;
            end else begin
              offset <= '0;
              state  <= STEP;
            end
          end else if (timer >= TO_W'(COLL_TIMEOUT - 1)) begin
            bump        <= 1'b1;
            step_active <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
`endif
        STEP: begin
          if (frame_tick && in_game) begin
            if (new_off >= OFF_W'(TILE_PX)) begin
              tx          <= dst_tx;
              ty          <= dst_ty;
              map_x       <= tile_px(dst_tx);
              map_y       <= tile_px(dst_ty);
              offset      <= '0;
              step_active <= 1'b0;
              state       <= IDLE;
            end else begin
              offset <= new_off;
              case (dir_q)
                2'd0:    map_y <= map_y + step_px;
                2'd1:    map_y <= map_y - step_px;
                2'd2:    map_x <= map_x - step_px;
                default: map_x <= map_x + step_px;
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl. Every change of the visible
// output snapshot is popped against a queue of hand-computed snapshots.
// Collision-lookup scenarios are compiled in when COLLISION_EN is defined.
`timescale 1ns/1ps
module tb_player_motion_ctrl;

`ifdef COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       VGA_VS = 1'b0;
  logic [3:0] state_num = 4'd3;
  logic       charIsMoving = 1'b0;
  logic       charIsRunning = 1'b0;
  logic [1:0] direction = 2'd0;
  logic [9:0] map_x, map_y;
  logic [1:0] facing;
  logic       step_active, bump;

  logic       resp_en = 1'b1;
  logic       resp_blocked = 1'b0;

  player_motion_ctrl_if coll();

  player_motion_ctrl #(
    .TILE_PX(16), .MAP_W(64), .MAP_H(64),
    .START_TX(10), .START_TY(12), .COLL_TIMEOUT(15)
  ) dut (
    .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .state_num(state_num),
    .charIsMoving(charIsMoving), .charIsRunning(charIsRunning),
    .direction(direction), .coll(coll.master),
    .map_x(map_x), .map_y(map_y), .facing(facing),
    .step_active(step_active), .bump(bump)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  f;
    logic        sa;
    logic        b;
    logic        req;
    logic [11:0] addr;
  } snap_t;

  snap_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_addr = '0;

  task automatic push(input int x, input int y, input int f,
                      input int sa, input int b, input int req);
    snap_t s;
    s.x = 10'(x); s.y = 10'(y); s.f = 2'(f);
    s.sa = 1'(sa); s.b = 1'(b); s.req = 1'(req);
    s.addr = exp_addr;
    exp_q.push_back(s);
  endtask

  // Expected snapshots when a step into tile (ttx,tty) is accepted
  task automatic push_start(input int x, input int y, input int f,
                            input int ttx, input int tty);
    if (COLL_EN) begin
      exp_addr = 12'(tty * 64 + ttx);
      push(x, y, f, 1, 0, 1);
    end
    push(x, y, f, 1, 0, 0);
  endtask

  task automatic frame();
    @(negedge Clk); VGA_VS = 1'b1;
    repeat (5) @(negedge Clk);
    VGA_VS = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  // Collision map model: answers two clocks after a request
  initial begin
    coll.coll_valid = 1'b0;
    coll.coll_data  = 1'b0;
    forever begin
      @(negedge Clk);
      if (coll.coll_req && resp_en) begin
        repeat (2) @(negedge Clk);
        coll.coll_valid = 1'b1;
        coll.coll_data  = resp_blocked;
        @(negedge Clk);
        coll.coll_valid = 1'b0;
        coll.coll_data  = 1'b0;
      end
    end
  end

  // Monitor: compare each output change against the scoreboard
  snap_t mon_prev = '1;
  snap_t mon_cur, mon_exp;
  logic  mon_bprev = 1'b0;
  initial begin
    forever begin
      @(negedge Clk);
      mon_cur = {map_x, map_y, facing, step_active, bump, coll.coll_req, coll.coll_addr};
      if (mon_bprev) begin
        checks++;
        if (bump) begin
          errors++;
          $display("FAIL bump_width got bump=1 two clocks running want single-clock pulse");
        end
      end
      mon_bprev = bump;
      if (mon_cur !== mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got x=%0d y=%0d f=%0d sa=%0b b=%0b req=%0b addr=%0d want no change",
                   mon_cur.x, mon_cur.y, mon_cur.f, mon_cur.sa, mon_cur.b, mon_cur.req, mon_cur.addr);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            errors++;
            $display("FAIL snapshot got x=%0d y=%0d f=%0d sa=%0b b=%0b req=%0b addr=%0d want x=%0d y=%0d f=%0d sa=%0b b=%0b req=%0b addr=%0d",
                     mon_cur.x, mon_cur.y, mon_cur.f, mon_cur.sa, mon_cur.b, mon_cur.req, mon_cur.addr,
                     mon_exp.x, mon_exp.y, mon_exp.f, mon_exp.sa, mon_exp.b, mon_exp.req, mon_exp.addr);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int px;
    int n;
    int lat;
    // reset state, then idle frames with no move request
    push(160, 192, 0, 0, 0, 0);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) frame();

    // walk right; mid-step input changes must be ignored
    charIsMoving = 1'b1; direction = 2'd3; charIsRunning = 1'b0;
    push_start(160, 192, 3, 11, 12);
    frame();
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) begin direction = 2'd0; charIsRunning = 1'b1; end
      if (k == 4) charIsMoving = 1'b0;
      push(160 + k, 192, 3, (k < 16) ? 1 : 0, 0, 0);
      frame();
    end

    // run up: even pixel values only
    charIsMoving = 1'b1; charIsRunning = 1'b1; direction = 2'd1;
    push_start(176, 192, 1, 11, 11);
    frame();
    charIsMoving = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push(176, 192 - 2 * k, 1, (k < 8) ? 1 : 0, 0, 0);
      frame();
    end

`ifdef COLLISION_EN
    // blocked tile: facing updates, position unchanged, bump pulse
    resp_en = 1'b1; resp_blocked = 1'b1;
    charIsMoving = 1'b1; charIsRunning = 1'b0; direction = 2'd0;
    push_start(176, 176, 0, 11, 12);
    push(176, 176, 0, 0, 1, 0);
    push(176, 176, 0, 0, 0, 0);
    frame();
    charIsMoving = 1'b0;

    // no response: bump exactly 15 clocks after coll_req
    resp_en = 1'b0;
    charIsMoving = 1'b1; direction = 2'd2;
    push_start(176, 176, 2, 10, 11);
    push(176, 176, 2, 0, 1, 0);
    push(176, 176, 2, 0, 0, 0);
    @(negedge Clk); VGA_VS = 1'b1;
    n = 0;
    while (!coll.coll_req && n < 20) begin @(negedge Clk); n++; end
    lat = 0;
    while (!bump && lat < 40) begin @(negedge Clk); lat++; end
    checks++;
    if (lat != 15) begin
      errors++;
      $display("FAIL timeout_latency got %0d clocks want 15", lat);
    end
    VGA_VS = 1'b0;
    charIsMoving = 1'b0;
    repeat (5) @(negedge Clk);
    resp_en = 1'b1; resp_blocked = 1'b0;
`endif

    // run left, consecutive steps, to the map's left edge
    charIsMoving = 1'b1; charIsRunning = 1'b1; direction = 2'd2;
    for (int t = 0; t <= 10; t++) begin
      px = (11 - t) * 16;
      push_start(px, 176, 2, 10 - t, 11);
      frame();
      for (int k = 1; k <= 8; k++) begin
        push(px - 2 * k, 176, 2, (k < 8) ? 1 : 0, 0, 0);
        frame();
      end
    end
    // out-of-map: bump without any collision request
    push(0, 176, 2, 0, 1, 0);
    push(0, 176, 2, 0, 0, 0);
    frame();
    charIsMoving = 1'b0; charIsRunning = 1'b0;

    // walk down, freeze at offset 5 while out of game state
    charIsMoving = 1'b1; direction = 2'd0;
    push_start(0, 176, 0, 0, 12);
    frame();
    charIsMoving = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(0, 176 + k, 0, 1, 0, 0);
      frame();
    end
    state_num = 4'd0;
    repeat (3) frame();
    state_num = 4'd3;
    for (int k = 6; k <= 16; k++) begin
      push(0, 176 + k, 0, (k < 16) ? 1 : 0, 0, 0);
      frame();
    end

    // reset in the middle of a step abandons it
    charIsMoving = 1'b1; direction = 2'd3;
    push_start(0, 192, 3, 1, 12);
    frame();
    charIsMoving = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push(k, 192, 3, 1, 0, 0);
      frame();
    end
    exp_addr = '0;
    push(160, 192, 0, 0, 0, 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) frame();

    repeat (10) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
